// File: rtl/dl_frame_tx.sv
// dl_frame_tx: periodic framed telemetry transmitter (8N1 UART) for the delay-line TDC.
// Latency: a frame starts the cycle after each report tick; measurements land in the holding register one cycle after meas_valid.
// Backpressure: none; ticks that arrive while a frame is in flight are dropped, and strobes arriving while the held value is still unsent bump a saturating drop count.
//
// Ports:
//   clk10m      system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   meas_valid  one-cycle strobe qualifying meas_data
//   meas_data   TDC measurement (MEAS_W bits)
//   txd         UART serial output, idles high
//   busy        high while a frame is being shifted out
//   frame_done  one-cycle pulse on the cycle after the last stop bit
//
// Optional feature: define DL_FRAME_CSUM_EN to append a checksum byte
// (sum modulo 256 of status and payload bytes, sync byte excluded).
module dl_frame_tx #(
    parameter int         SYSTEM_FREQ = 10000000,
    parameter int         TARGET_FREQ = 30,
    parameter int         BAUD        = 115200,
    parameter int         MEAS_W      = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hAA
) (
    input  logic              clk10m,
    input  logic              rst,
    input  logic              meas_valid,
    input  logic [MEAS_W-1:0] meas_data,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int TICK_DIV     = SYSTEM_FREQ / TARGET_FREQ;
    localparam int CLKS_PER_BIT = SYSTEM_FREQ / BAUD;
    localparam int NBYTES       = (MEAS_W + 7) / 8;
    localparam int PAY_W        = NBYTES * 8;
`ifdef DL_FRAME_CSUM_EN
    localparam int CSUM_BYTES   = 1;
`else
    localparam int CSUM_BYTES   = 0;
`endif
    localparam int FRAME_BYTES  = 2 + NBYTES + CSUM_BYTES;

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(FRAME_BYTES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(FRAME_BYTES - 1);
    localparam logic [6:0]    DROP_MAX  = 7'd127;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Report-rate tick: free-running, phase restarts on reset.
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk10m) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [BW-1:0] byte_idx, byte_idx_n;
    logic          done_n;
    logic          txd_n;
    logic          frame_start;

    assign frame_start = (state == IDLE) && tick;
    assign busy        = (state != IDLE);

    // ------------------------------------------------------------------
    // Capture and freshness/drop accounting. A frame start snapshots the
    // pre-edge values and restarts accounting; a coincident strobe then
    // becomes the first fresh sample of the next reporting interval.
    // ------------------------------------------------------------------
    logic [MEAS_W-1:0] hold;
    logic              fresh;
    logic [6:0]        drop;
    logic [PAY_W-1:0]  frm_data;
    logic              frm_fresh;
    logic [6:0]        frm_drop;
    logic [7:0]        status;

    assign status = {frm_fresh, frm_drop};

    always_ff @(posedge clk10m) begin
        if (rst) begin
            hold      <= '0;
            fresh     <= 1'b0;
            drop      <= '0;
            frm_data  <= '0;
            frm_fresh <= 1'b0;
            frm_drop  <= '0;
        end else if (frame_start) begin
            frm_data  <= PAY_W'(hold);
            frm_fresh <= fresh;
            frm_drop  <= drop;
            drop      <= '0;
            fresh     <= meas_valid;
            if (meas_valid) begin
                hold <= meas_data;
            end
        end else if (meas_valid) begin
            hold  <= meas_data;
            fresh <= 1'b1;
            if (fresh && (drop != DROP_MAX)) begin
                drop <= drop + 7'd1;
            end
        end
    end

`ifdef DL_FRAME_CSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = status;
        for (int k = 0; k < NBYTES; k++) begin
            csum = csum + frm_data[k*8 +: 8];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (tick) begin
                    state_n    = START;
                    clk_cnt_n  = '0;
                    byte_idx_n = '0;
                end
            end
            START: begin
                if (clk_cnt == CLK_LAST) begin
                    state_n   = DATA;
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    if (byte_idx == BYTE_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = START;
                        byte_idx_n = byte_idx + BW'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Byte selected by the upcoming byte index; frame registers are already
    // loaded by the time any data bit of the frame is driven.
    logic [7:0] cur_byte;

    always_comb begin
        cur_byte = SYNC_BYTE;
        if (byte_idx_n == BW'(1)) begin
            cur_byte = status;
        end
        for (int k = 0; k < NBYTES; k++) begin
            if (byte_idx_n == BW'(k + 2)) begin
                cur_byte = frm_data[k*8 +: 8];
            end
        end
`ifdef DL_FRAME_CSUM_EN
        if (byte_idx_n == BW'(NBYTES + 2)) begin
            cur_byte = csum;
        end
`endif
    end

    // txd is registered from the next state so the line never glitches.
    always_comb begin
        txd_n = 1'b1;
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = cur_byte[bit_idx_n];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk10m) begin
        if (rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            txd        <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_cnt_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            txd        <= txd_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_dl_frame_tx.sv
// tb_dl_frame_tx: directed bench for dl_frame_tx, decoding txd bit by bit.
// Scaled parameters: TICK_DIV = 4000/8 = 500 cycles, CLKS_PER_BIT = 4000/1000 = 4.
// Expected frames are written out byte by byte (byte 0 in the low bits).
`timescale 1ns/1ps
module tb_dl_frame_tx;

    localparam int SYS    = 4000;
    localparam int TGT    = 8;
    localparam int BAUD_R = 1000;
    localparam int TD     = 500;
    localparam int CPB    = 4;
`ifdef DL_FRAME_CSUM_EN
    localparam int FB     = 5;
`else
    localparam int FB     = 4;
`endif
    localparam int LEN    = 10 * FB * CPB;

    logic        clk10m     = 1'b0;
    logic        rst        = 1'b1;
    logic        meas_valid = 1'b0;
    logic [15:0] meas_data  = 16'h0000;
    logic        txd;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    dl_frame_tx #(
        .SYSTEM_FREQ (SYS),
        .TARGET_FREQ (TGT),
        .BAUD        (BAUD_R),
        .MEAS_W      (16),
        .SYNC_BYTE   (8'hAA)
    ) dut (
        .clk10m     (clk10m),
        .rst        (rst),
        .meas_valid (meas_valid),
        .meas_data  (meas_data),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk10m = ~clk10m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk10m);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic strobe(input logic [15:0] d);
        meas_valid = 1'b1;
        meas_data  = d;
        step();
        meas_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int exp_c);
        int guard;
        guard = 0;
        while (busy !== 1'b1 && guard < 2 * TD) begin
            step();
            guard++;
        end
        chk({tag, ".start_cycle"}, 64'(cyc), 64'(exp_c));
        chk({tag, ".start_bit"}, 64'(txd), 64'(0));
    endtask

    task automatic rx_frame(input string tag, input int s, input logic [39:0] exp);
        logic [9:0] sh;
        int ferr;
        int blow;
        ferr = 0;
        blow = 0;
        sh   = '0;
        for (int j = 0; j < FB; j++) begin
            for (int b = 0; b < 10; b++) begin
                goto(s + (10 * j + b) * CPB + CPB / 2);
                sh[b] = txd;
                if (busy !== 1'b1) blow++;
            end
            if (sh[0] !== 1'b0 || sh[9] !== 1'b1) ferr++;
            chk($sformatf("%s.byte%0d", tag, j), 64'(sh[8:1]), 64'(exp[j*8 +: 8]));
        end
        chk({tag, ".framing_errs"}, 64'(ferr), 64'(0));
        chk({tag, ".busy_gaps"}, 64'(blow), 64'(0));
        goto(s + LEN - 1);
        chk({tag, ".busy_last"}, 64'(busy), 64'(1));
        chk({tag, ".done_early"}, 64'(frame_done), 64'(0));
        step();
        chk({tag, ".busy_end"}, 64'(busy), 64'(0));
        chk({tag, ".done"}, 64'(frame_done), 64'(1));
        chk({tag, ".txd_idle"}, 64'(txd), 64'(1));
        step();
        chk({tag, ".done_pulse"}, 64'(frame_done), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) step();
        chk("rst.txd", 64'(txd), 64'(1));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(frame_done), 64'(0));
        rst = 1'b0;
        cyc = 0;

        // No measurement yet: stale all-zero frame.
        wait_start("f1", TD);
        rx_frame("f1", TD, 40'h00_00_00_00_AA);

        // One fresh sample, then the same value reported stale.
        goto(TD + 250);
        strobe(16'h1234);
        wait_start("f2", 2 * TD);
        rx_frame("f2", 2 * TD, 40'hC6_12_34_80_AA);
        wait_start("f3", 3 * TD);
        rx_frame("f3", 3 * TD, 40'h46_12_34_00_AA);

        // Three samples in one interval: two drops.
        strobe(16'h0001);
        strobe(16'h0002);
        strobe(16'h0003);
        wait_start("f4", 4 * TD);
        rx_frame("f4", 4 * TD, 40'h85_00_03_82_AA);

        // 200 back-to-back samples: drop count saturates at 127.
        for (int i = 1; i <= 200; i++) begin
            meas_valid = 1'b1;
            meas_data  = 16'(i);
            step();
        end
        meas_valid = 1'b0;
        wait_start("f5", 5 * TD);
        rx_frame("f5", 5 * TD, 40'hC7_00_C8_FF_AA);

        // Sample on the tick cycle belongs to the following frame.
        goto(6 * TD - 1);
        meas_valid = 1'b1;
        meas_data  = 16'hBEEF;
        step();
        meas_valid = 1'b0;
        wait_start("f6", 6 * TD);
        rx_frame("f6", 6 * TD, 40'hC8_00_C8_00_AA);
        wait_start("f7", 7 * TD);
        rx_frame("f7", 7 * TD, 40'h2D_BE_EF_80_AA);

        // Reset in the middle of the payload wipes accounting and tick phase.
        strobe(16'h5555);
        strobe(16'h5555);
        wait_start("f8", 8 * TD);
        goto(8 * TD + 2 * 10 * CPB + 10);
        rst = 1'b1;
        step();
        chk("mid_rst.txd", 64'(txd), 64'(1));
        chk("mid_rst.busy", 64'(busy), 64'(0));
        chk("mid_rst.done", 64'(frame_done), 64'(0));
        step();
        chk("mid_rst.done_hold", 64'(frame_done), 64'(0));
        step();
        rst = 1'b0;
        cyc = 0;
        wait_start("f9", TD);
        rx_frame("f9", TD, 40'h00_00_00_00_AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dl_frame_tx.md
# dl_frame_tx

Periodic framed telemetry transmitter for the delay-line TDC platform. Latches TDC measurements as they arrive and, at a programmable report rate, sends a sync byte, a status byte and the little-endian measurement over an integrated 8N1 UART to the MCU. It generalises the fixed 30 Hz single-byte beacon to any measurement width, baud rate and report rate, and adds freshness/drop accounting and an optional checksum.

## Interface
- SYSTEM_FREQ, 10000000: clk10m frequency in Hz.
- TARGET_FREQ, 30: frame report rate in Hz; TICK_DIV = SYSTEM_FREQ/TARGET_FREQ (integer division).
- BAUD, 115200: UART bit rate; CLKS_PER_BIT = SYSTEM_FREQ/BAUD (integer division, 86 at defaults).
- MEAS_W, 16: measurement width, 1..64; NBYTES = ceil(MEAS_W/8).
- SYNC_BYTE, 8'hAA: first byte of every frame.
- clk10m  input  1  system clock; one clock domain, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- meas_valid  input  1  one-cycle strobe, meas_data valid.
- meas_data  input  MEAS_W  TDC measurement.
- txd  output  1  UART serial out, idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse at end of a frame.

## Operation
- Reset values: txd=1, busy=0, frame_done=0; tick counter=0, holding register=0, fresh=0, drop count=0, FSM=IDLE.
- Tick counter: counts 0..TICK_DIV-1 free-running, wraps; tick asserted on the cycle count==TICK_DIV-1.
- Capture: meas_valid=1 loads meas_data into holding, sets fresh. If fresh already 1, drop count increments, saturating at 127.
- Frame start: tick while FSM=IDLE. Snapshot holding, fresh, drop count into frame registers. Ticks while busy are ignored, not queued.
- Same-cycle tick+meas_valid: frame uses pre-edge holding/fresh/drop; after the edge holding=meas_data, fresh=1, drop=0. Tick without meas_valid: fresh=0, drop=0 after the edge.
- Frame bytes in order: SYNC_BYTE; status = {fresh, drop[6:0]}; NBYTES payload bytes, least significant first, zero-extended above MEAS_W; checksum byte if enabled.
- Stale frames (fresh=0) are still sent with the last held value.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly CLKS_PER_BIT cycles; next start bit immediately follows previous stop bit.
- FSM: IDLE -> START (on tick) -> DATA (8 bits) -> STOP -> START if more bytes remain, else IDLE. Byte index counts 0..FRAME_BYTES-1.
- Reset mid-frame: next cycle txd=1, busy=0, no frame_done, counters and accounting cleared; tick phase restarts from 0.

## Timing
- First tick at cycle TICK_DIV-1 after rst deasserted (counter 0 on first post-reset cycle).
- Start bit of byte 0 and busy=1 drive from the cycle after the tick.
- FRAME_BYTES = 2 + NBYTES (+1 with checksum). Frame length = 10*FRAME_BYTES*CLKS_PER_BIT cycles; defaults without checksum: 4 bytes, 3440 cycles.
- busy falls and frame_done pulses on the cycle after the final stop bit's last cycle; txd remains 1.
- Frame must fit in TICK_DIV cycles; otherwise every other tick is dropped (defined behaviour, no error flag).
- Capture latency: meas_data visible in holding one cycle after meas_valid.

## Configuration
- DL_FRAME_CSUM_EN defined: one extra byte appended = sum modulo 256 of status and all payload bytes (SYNC_BYTE excluded).
- Undefined: no checksum byte; FRAME_BYTES = 2 + NBYTES; all other behaviour identical.

## Test plan
- Defaults, no measurement after reset -> first frame starts cycle 333333 after reset release: bytes AA, 00, 00, 00; busy high 3440 cycles; frame_done single pulse.
- meas_valid once with 16'h1234 before tick -> frame AA, 80, 34, 12; following frame AA, 00, 34, 12.
- Three meas_valid (0x0001, 0x0002, 0x0003) between ticks -> AA, 82, 03, 00; 200 strobes -> status FF (drop saturates 127).
- meas_valid with 16'hBEEF on the tick cycle -> current frame carries prior value; next frame AA, 80, EF, BE.
- DL_FRAME_CSUM_EN, value 16'h1234 fresh -> AA, 80, 34, 12, C6; 5 bytes, 4300 cycles.
- rst asserted mid-payload -> txd=1 and busy=0 next cycle, no frame_done; next frame starts TICK_DIV cycles after release with status 00.
